// File: rtl/e_mdu_pkg.sv
// Shared CPU definitions for the multiply/divide unit: SPECIAL opcode, funct codes,
// operation latencies and the latched-operation encoding.
package e_mdu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;

  typedef enum logic [1:0] {MdMult, MdMultu, MdDiv, MdDivu} md_op_e;

endpackage

// File: rtl/mdu_decode.sv
// Combinational decoder for the multiply/divide group of SPECIAL instructions.
module mdu_decode
  import e_mdu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_start,
  output logic       is_mult,
  output logic       is_signed,
  output logic       is_mfhi,
  output logic       is_mflo,
  output logic       is_mthi,
  output logic       is_mtlo
);

  always_comb begin
    is_start  = 1'b0;
    is_mult   = 1'b0;
    is_signed = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    if (opcode == OP_SPECIAL) begin
      unique case (funct)
        FN_MULT:  begin is_start = 1'b1; is_mult = 1'b1; is_signed = 1'b1; end
        FN_MULTU: begin is_start = 1'b1; is_mult = 1'b1; end
        FN_DIV:   begin is_start = 1'b1; is_signed = 1'b1; end
        FN_DIVU:  is_start = 1'b1;
        FN_MFHI:  is_mfhi = 1'b1;
        FN_MFLO:  is_mflo = 1'b1;
        FN_MTHI:  is_mthi = 1'b1;
        FN_MTLO:  is_mtlo = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency countdown with the HI/LO result
// committed on the final busy edge, plus mfhi/mflo/mthi/mtlo access and stall request.
module e_mdu
  import e_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_IR,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        D_is_md,
  output logic        busy,
  output logic        start,
  output logic        MD_stall,
  output logic [31:0] E_MD_OUT
);

  logic is_start, is_mult, is_signed, is_mfhi, is_mflo, is_mthi, is_mtlo;

  mdu_decode u_decode (
    .opcode    (E_IR[31:26]),
    .funct     (E_IR[5:0]),
    .is_start  (is_start),
    .is_mult   (is_mult),
    .is_signed (is_signed),
    .is_mfhi   (is_mfhi),
    .is_mflo   (is_mflo),
    .is_mthi   (is_mthi),
    .is_mtlo   (is_mtlo)
  );

  logic unused_ir;
  assign unused_ir = ^E_IR[25:6];

  logic [31:0] hi, lo, a, b;
  logic [3:0]  cnt;
  md_op_e      op, op_new;

  logic [31:0] res_hi, res_lo;
  logic        res_we;

  assign busy     = (cnt != 4'd0);
  assign start    = is_start;
  assign MD_stall = D_is_md & (start | busy);
  assign E_MD_OUT = is_mfhi ? hi : (is_mflo ? lo : 32'd0);

  assign op_new = is_mult ? (is_signed ? MdMult : MdMultu) : (is_signed ? MdDiv : MdDivu);

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    res_we = 1'b1;
    unique case (op)
      MdMult:  {res_hi, res_lo} = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MdMultu: {res_hi, res_lo} = {32'd0, a} * {32'd0, b};
      MdDiv: begin
        if (b == 32'd0) begin
          res_we = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // Quotient overflows; keep the wrapped two's-complement result explicitly.
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $unsigned($signed(a) / $signed(b));
          res_hi = $unsigned($signed(a) % $signed(b));
        end
      end
      MdDivu: begin
        if (b == 32'd0) begin
          res_we = 1'b0;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi  <= 32'd0;
      lo  <= 32'd0;
      a   <= 32'd0;
      b   <= 32'd0;
      cnt <= 4'd0;
      op  <= MdMult;
    end else begin
      if (start && !busy) begin
        op  <= op_new;
        a   <= E_RS;
        b   <= E_RT;
        cnt <= is_mult ? MULT_CYC : DIV_CYC;
      end else if (busy) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1 && res_we) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
      if (is_mthi) hi <= E_RS;
      if (is_mtlo) lo <= E_RS;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu with hand-computed HI/LO and timing values.
module tb_e_mdu;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_ADD   = 32'h0109_4020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_IR, E_RS, E_RT;
  logic        D_is_md;
  logic        busy, start, MD_stall;
  logic [31:0] E_MD_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  e_mdu dut (
    .clk      (clk),
    .reset    (reset),
    .E_IR     (E_IR),
    .E_RS     (E_RS),
    .E_RT     (E_RT),
    .D_is_md  (D_is_md),
    .busy     (busy),
    .start    (start),
    .MD_stall (MD_stall),
    .E_MD_OUT (E_MD_OUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reads HI and LO through mfhi/mflo within the current cycle.
  task automatic read_hilo(output logic [31:0] hv, output logic [31:0] lv);
    E_IR = I_MFHI; #1; hv = E_MD_OUT;
    E_IR = I_MFLO; #1; lv = E_MD_OUT;
    E_IR = I_NOP;  #1;
  endtask

  // Issues one mult/div, then counts busy cycles; MD_stall must equal dmd throughout.
  task automatic run_md(input string tag, input logic [31:0] ir, input logic [31:0] rs,
                        input logic [31:0] rt, input logic dmd, input int exp_cyc);
    int n;
    E_IR = ir; E_RS = rs; E_RT = rt; D_is_md = dmd; #1;
    check({tag, "_start"}, {31'd0, start}, 32'd1);
    check({tag, "_stall_start"}, {31'd0, MD_stall}, {31'd0, dmd});
    step();
    E_IR = I_NOP; #1;
    n = 0;
    while (busy && n < 20) begin
      check({tag, "_stall_busy"}, {31'd0, MD_stall}, {31'd0, dmd});
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, n, exp_cyc);
    check({tag, "_stall_after"}, {31'd0, MD_stall}, 32'd0);
    D_is_md = 1'b0; #1;
  endtask

  logic [31:0] hv, lv;

  initial begin
    reset = 1'b1; E_IR = I_NOP; E_RS = '0; E_RT = '0; D_is_md = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    read_hilo(hv, lv);
    check("rst_hi", hv, 32'd0);
    check("rst_lo", lv, 32'd0);
    reset = 1'b0;
    step();

    run_md("mult", I_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 5);
    read_hilo(hv, lv);
    check("mult_hi", hv, 32'hFFFF_FFFF);
    check("mult_lo", lv, 32'hFFFF_FFFE);

    run_md("multu", I_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 5);
    read_hilo(hv, lv);
    check("multu_hi", hv, 32'h0000_0001);
    check("multu_lo", lv, 32'hFFFF_FFFE);

    run_md("div", I_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 10);
    read_hilo(hv, lv);
    check("div_hi", hv, 32'hFFFF_FFFF);
    check("div_lo", lv, 32'hFFFF_FFFD);

    run_md("div0", I_DIV, 32'd1234, 32'd0, 1'b0, 10);
    read_hilo(hv, lv);
    check("div0_hi", hv, 32'hFFFF_FFFF);
    check("div0_lo", lv, 32'hFFFF_FFFD);

    run_md("divovf", I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10);
    read_hilo(hv, lv);
    check("divovf_hi", hv, 32'd0);
    check("divovf_lo", lv, 32'h8000_0000);

    run_md("divu", I_DIVU, 32'd100, 32'd7, 1'b0, 10);
    read_hilo(hv, lv);
    check("divu_hi", hv, 32'd2);
    check("divu_lo", lv, 32'd14);

    // mflo waiting in D stalls until the product lands, then sees the new LO.
    run_md("stall", I_MULT, 32'd3, 32'd5, 1'b1, 5);
    E_IR = I_MFLO; #1;
    check("stall_mflo", E_MD_OUT, 32'd15);

    // add in D alongside a busy multiply does not stall.
    E_IR = I_MULTU; E_RS = 32'd6; E_RT = 32'd7; D_is_md = 1'b0; #1;
    step();
    E_IR = I_ADD; #1;
    check("add_busy", {31'd0, busy}, 32'd1);
    check("add_nostall", {31'd0, MD_stall}, 32'd0);
    E_IR = I_NOP;
    repeat (6) step();
    read_hilo(hv, lv);
    check("add_multu_lo", lv, 32'd42);

    E_IR = I_MTHI; E_RS = 32'h1234_5678; #1;
    check("mthi_nostart", {31'd0, start}, 32'd0);
    step();
    E_IR = I_MFHI; #1;
    check("mthi_mfhi", E_MD_OUT, 32'h1234_5678);
    E_IR = I_MTLO; E_RS = 32'hCAFE_0001; #1;
    step();
    E_IR = I_MFLO; #1;
    check("mtlo_mflo", E_MD_OUT, 32'hCAFE_0001);
    E_IR = I_NOP; #1;

    // Reset during busy cycle 3 of a divide.
    E_IR = I_DIV; E_RS = 32'd77; E_RT = 32'd5; #1;
    step();
    E_IR = I_NOP;
    step();
    step();
    check("rstmid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1; #1;
    check("rstmid_busy_async", {31'd0, busy}, 32'd0);
    E_IR = I_MFHI; #1;
    check("rstmid_mfhi_in_reset", E_MD_OUT, 32'd0);
    E_IR = I_NOP;
    step();
    reset = 1'b0;
    repeat (12) step();
    check("rstmid_busy_after", {31'd0, busy}, 32'd0);
    read_hilo(hv, lv);
    check("rstmid_hi", hv, 32'd0);
    check("rstmid_lo", lv, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
